// File: rtl/icache_loader_if.sv
// Program-stream and I-cache port A bundle for the icache loader.
// master = environment (stream source + cache RAM), slave = loader.
interface icache_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        Wen_FIO_ICache;
  logic [9:0]  Addr_FIO_ICache;
  logic [31:0] Din_FIO_ICache;
  logic [31:0] Dout_FIO_ICache;

  modport master (
    output in_valid, in_data, Dout_FIO_ICache,
    input  in_ready, Wen_FIO_ICache, Addr_FIO_ICache, Din_FIO_ICache
  );

  modport slave (
    input  in_valid, in_data, Dout_FIO_ICache,
    output in_ready, Wen_FIO_ICache, Addr_FIO_ICache, Din_FIO_ICache
  );
endinterface

// File: rtl/icache_loader.sv
// icache_loader: streams N program words into the I-cache, reads them back
// to compare a modulo-2^32 running sum, then enables the requested warps.
module icache_loader (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [10:0]    word_count,
  input  logic [7:0]     warp_mask,
  icache_loader_if.slave bus,
  output logic [7:0]     PC_Valid,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [1:0]     err_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_VERIFY = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t      state_r;
  logic [10:0] n_r;
  logic [7:0]  mask_r;
  logic [10:0] wr_cnt_r;
  logic [10:0] rd_cnt_r;
  logic [31:0] sum_w_r;
  logic [31:0] sum_rd_r;
  logic        in_ready_r;
  logic        wen_r;
  logic [9:0]  addr_r;
  logic [31:0] din_r;
  logic [7:0]  pc_valid_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic [1:0]  err_code_r;

  logic        xfer_s;
  logic        wc_legal_s;
  logic [10:0] rd_next_s;

  // Legal load length is 1..1024 words.
  function automatic logic count_legal(input logic [10:0] wc);
    return (wc != 11'd0) && (wc <= 11'd1024);
  endfunction

  // Stream handshake, length qualification and next read address.
  always_comb begin
    xfer_s     = bus.in_valid && in_ready_r;
    wc_legal_s = count_legal(word_count);
    rd_next_s  = rd_cnt_r + 11'd1;
  end

  // Load / verify sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      n_r        <= 11'd0;
      mask_r     <= 8'd0;
      wr_cnt_r   <= 11'd0;
      rd_cnt_r   <= 11'd0;
      sum_w_r    <= 32'd0;
      sum_rd_r   <= 32'd0;
      in_ready_r <= 1'b0;
      wen_r      <= 1'b0;
      addr_r     <= 10'd0;
      din_r      <= 32'd0;
      pc_valid_r <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= 2'b00;
    end else if (abort) begin
      // Abort beats everything, including a write that would follow this cycle.
      state_r    <= S_IDLE;
      wr_cnt_r   <= 11'd0;
      rd_cnt_r   <= 11'd0;
      sum_w_r    <= 32'd0;
      sum_rd_r   <= 32'd0;
      in_ready_r <= 1'b0;
      wen_r      <= 1'b0;
      addr_r     <= 10'd0;
      din_r      <= 32'd0;
      pc_valid_r <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= 2'b00;
    end else begin
      // A write appears only in the cycle right after a stream transfer.
      wen_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            if (wc_legal_s) begin
              state_r    <= S_LOAD;
              n_r        <= word_count;
              mask_r     <= warp_mask;
              wr_cnt_r   <= 11'd0;
              rd_cnt_r   <= 11'd0;
              sum_w_r    <= 32'd0;
              sum_rd_r   <= 32'd0;
              in_ready_r <= 1'b1;
              pc_valid_r <= 8'd0;
              busy_r     <= 1'b1;
              done_r     <= 1'b0;
              error_r    <= 1'b0;
              err_code_r <= 2'b00;
            end else begin
              state_r    <= S_ERROR;
              in_ready_r <= 1'b0;
              pc_valid_r <= 8'd0;
              busy_r     <= 1'b0;
              done_r     <= 1'b0;
              error_r    <= 1'b1;
              err_code_r <= 2'b01;
            end
          end
        end
        S_LOAD: begin
          if (xfer_s) begin
            wen_r    <= 1'b1;
            addr_r   <= wr_cnt_r[9:0];
            din_r    <= bus.in_data;
            wr_cnt_r <= wr_cnt_r + 11'd1;
            sum_w_r  <= sum_w_r + bus.in_data;
            if (wr_cnt_r == (n_r - 11'd1)) begin
              state_r    <= S_DRAIN;
              in_ready_r <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Last write is on the port now; first read address goes out next.
          state_r  <= S_VERIFY;
          addr_r   <= 10'd0;
          rd_cnt_r <= 11'd0;
        end
        S_VERIFY: begin
          // rd_cnt counts VERIFY cycles; read data lags its address by one.
          rd_cnt_r <= rd_next_s;
          if (rd_cnt_r != 11'd0) begin
            sum_rd_r <= sum_rd_r + bus.Dout_FIO_ICache;
          end
          if (rd_cnt_r == n_r) begin
            state_r <= S_CHECK;
            addr_r  <= 10'd0;
          end else if (rd_next_s < n_r) begin
            addr_r <= rd_next_s[9:0];
          end else begin
            addr_r <= 10'd0;
          end
        end
        S_CHECK: begin
          busy_r <= 1'b0;
          if (sum_rd_r == sum_w_r) begin
            state_r    <= S_DONE;
            done_r     <= 1'b1;
            pc_valid_r <= mask_r;
          end else begin
            state_r    <= S_ERROR;
            error_r    <= 1'b1;
            err_code_r <= 2'b10;
            pc_valid_r <= 8'd0;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          in_ready_r <= 1'b0;
          pc_valid_r <= 8'd0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          error_r    <= 1'b0;
          err_code_r <= 2'b00;
        end
      endcase
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.Wen_FIO_ICache  = wen_r;
  assign bus.Addr_FIO_ICache = addr_r;
  assign bus.Din_FIO_ICache  = din_r;
  assign PC_Valid            = pc_valid_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign error               = error_r;
  assign err_code            = err_code_r;

endmodule

// File: tb/tb_icache_loader.sv
// Self-checking bench for icache_loader: cache RAM model, stream driver,
// and a behavioural model compared against the DUT on every falling edge.
module tb_icache_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [10:0] word_count;
  logic [7:0]  warp_mask;
  logic [7:0]  PC_Valid;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  icache_loader_if bus ();

  icache_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .word_count (word_count),
    .warp_mask  (warp_mask),
    .bus        (bus),
    .PC_Valid   (PC_Valid),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment: RAM contents, fault injection, write bookkeeping.
  logic [31:0] mem [0:1023];
  logic        fault_en;
  logic [9:0]  fault_addr;
  int          wen_count = 0;
  logic [9:0]  last_waddr = 10'd0;
  logic [31:0] words [0:1023];

  // Model state.
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_VER = 3,
                 P_CHK = 4, P_DONE = 5, P_ERR = 6;
  int          ph, mN, acc, vk;
  logic [7:0]  mmask;
  logic [31:0] msumw, rsum;
  logic [31:0] exp_words [0:1023];
  logic        e_ready, e_wen, e_busy, e_done, e_err;
  logic [1:0]  e_ec;
  logic [7:0]  e_pcv;
  logic [9:0]  e_addr;
  logic [31:0] e_din;
  logic        chk_ad, chk_din, xfer;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read cache RAM with optional bit-0 flip on one address.
  always @(posedge clk) begin
    if (bus.Wen_FIO_ICache) begin
      mem[bus.Addr_FIO_ICache] <= bus.Din_FIO_ICache;
      wen_count                <= wen_count + 1;
      last_waddr               <= bus.Addr_FIO_ICache;
    end
    bus.Dout_FIO_ICache <= mem[bus.Addr_FIO_ICache] ^
                           {31'd0, (fault_en && (bus.Addr_FIO_ICache == fault_addr))};
  end

  // Behavioural model of the edge just passed, then compare the DUT with it.
  always @(negedge clk) begin
    chk_ad  = 1'b0;
    chk_din = 1'b0;
    if (!rst_n || abort) begin
      ph = P_IDLE;
      e_ready = 1'b0; e_wen = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_ec = 2'b00; e_pcv = 8'd0; e_addr = 10'd0; e_din = 32'd0;
      chk_ad = 1'b1; chk_din = 1'b1;
    end else begin
      xfer  = bus.in_valid && e_ready;
      e_wen = 1'b0;
      case (ph)
        P_IDLE, P_DONE, P_ERR: begin
          if (start) begin
            e_done = 1'b0; e_pcv = 8'd0;
            if (word_count >= 11'd1 && word_count <= 11'd1024) begin
              ph = P_LOAD; mN = int'(word_count); mmask = warp_mask;
              acc = 0; msumw = 32'd0;
              e_ready = 1'b1; e_busy = 1'b1; e_err = 1'b0; e_ec = 2'b00;
            end else begin
              ph = P_ERR; e_ready = 1'b0; e_busy = 1'b0; e_err = 1'b1; e_ec = 2'b01;
            end
          end
        end
        P_LOAD: begin
          if (xfer) begin
            e_wen = 1'b1; e_addr = acc[9:0]; e_din = bus.in_data;
            exp_words[acc] = bus.in_data;
            msumw = msumw + bus.in_data;
            acc++;
            chk_ad = 1'b1; chk_din = 1'b1;
            if (acc == mN) begin
              ph = P_DRAIN; e_ready = 1'b0;
            end
          end
        end
        P_DRAIN: begin
          ph = P_VER; vk = 0; e_addr = 10'd0; chk_ad = 1'b1;
        end
        P_VER: begin
          if (vk == mN) begin
            ph = P_CHK;
          end else begin
            vk++;
            if (vk < mN) begin
              e_addr = vk[9:0]; chk_ad = 1'b1;
            end
          end
        end
        P_CHK: begin
          rsum = 32'd0;
          for (int k = 0; k < mN; k++)
            rsum = rsum + (exp_words[k] ^ {31'd0, (fault_en && (k == int'(fault_addr)))});
          e_busy = 1'b0;
          if (rsum == msumw) begin
            ph = P_DONE; e_done = 1'b1; e_pcv = mmask;
          end else begin
            ph = P_ERR; e_err = 1'b1; e_ec = 2'b10; e_pcv = 8'd0;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, e_ready});
    chk("wen", {31'd0, bus.Wen_FIO_ICache}, {31'd0, e_wen});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("error", {31'd0, error}, {31'd0, e_err});
    chk("err_code", {30'd0, err_code}, {30'd0, e_ec});
    chk("pc_valid", {24'd0, PC_Valid}, {24'd0, e_pcv});
    if (chk_ad)  chk("addr", {22'd0, bus.Addr_FIO_ICache}, {22'd0, e_addr});
    if (chk_din) chk("din", bus.Din_FIO_ICache, e_din);
  end

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_wen"}, {31'd0, bus.Wen_FIO_ICache}, 32'd0);
    chk({tag, "_addr"}, {22'd0, bus.Addr_FIO_ICache}, 32'd0);
    chk({tag, "_din"}, bus.Din_FIO_ICache, 32'd0);
    chk({tag, "_pcv"}, {24'd0, PC_Valid}, 32'd0);
    chk({tag, "_busy_done_err"}, {29'd0, busy, done, error}, 32'd0);
    chk({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
  endtask

  task automatic pulse_start(input logic [10:0] wc, input logic [7:0] mask);
    @(negedge clk); #1;
    start = 1'b1; word_count = wc; warp_mask = mask;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid + stray starts.
  task automatic send_words(input int n, input int mode);
    int idx, it, budget;
    bit vprev, rprev;
    idx = 0; it = 0; vprev = 1'b0; rprev = 1'b0; budget = n * 8 + 40;
    while (idx < n && budget > 0) begin
      @(negedge clk);
      if (vprev && rprev) idx++;
      if (idx < n) begin
        budget--;
        #1;
        rprev = bus.in_ready;
        case (mode)
          0:       vprev = 1'b1;
          1:       vprev = ((it % 2) == 0);
          default: vprev = ($urandom_range(0, 1) == 1);
        endcase
        it++;
        bus.in_valid = vprev;
        bus.in_data  = vprev ? words[idx] : $urandom;
        if (mode == 2) begin
          start      = ($urandom_range(0, 7) == 0);
          word_count = 11'($urandom_range(0, 2047));
        end
      end
    end
    chk("send_complete", idx, n);
    #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy && c < budget);
    chk("wait_done_timeout", {31'd0, busy}, 32'd0);
    #1;
  endtask

  task automatic check_mem(input int n);
    for (int i = 0; i < n; i++) chk("mem", mem[i], words[i]);
  endtask

  int n, r, w0, npart;

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; word_count = 11'd0; warp_mask = 8'd0;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; fault_en = 1'b0; fault_addr = 10'd0;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Four words, ideal memory, mask 0x0F.
    for (int i = 0; i < 4; i++) words[i] = 32'(i + 1);
    w0 = wen_count;
    pulse_start(11'd4, 8'h0F);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send_words(4, 0);
    wait_done(40);
    chk("basic_sum", msumw, 32'h0000000A);
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_pcv", {24'd0, PC_Valid}, 32'h0F);
    chk("basic_wen_count", wen_count - w0, 32'd4);
    chk("basic_mem3", mem[3], 32'h4);
    check_mem(4);

    // Same load with in_valid dropped every other cycle.
    w0 = wen_count;
    pulse_start(11'd4, 8'h0F);
    send_words(4, 1);
    wait_done(40);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_pcv", {24'd0, PC_Valid}, 32'h0F);
    chk("gap_wen_count", wen_count - w0, 32'd4);
    check_mem(4);

    // Illegal lengths: 0 and 1025.
    w0 = wen_count;
    pulse_start(11'd0, 8'hFF);
    chk("wc0_error", {31'd0, error}, 32'd1);
    chk("wc0_err_code", {30'd0, err_code}, 32'd1);
    pulse_start(11'd1025, 8'hFF);
    chk("wc1025_error", {31'd0, error}, 32'd1);
    chk("wc1025_err_code", {30'd0, err_code}, 32'd1);
    chk("illegal_no_wen", wen_count - w0, 32'd0);

    // Bit-0 flip on read of address 2.
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    fault_en = 1'b1; fault_addr = 10'd2;
    pulse_start(11'd8, 8'hA5);
    send_words(8, 0);
    wait_done(40);
    chk("fault_error", {31'd0, error}, 32'd1);
    chk("fault_err_code", {30'd0, err_code}, 32'd2);
    chk("fault_pcv", {24'd0, PC_Valid}, 32'd0);
    fault_en = 1'b0;

    // Full 1024-word load of all-ones.
    for (int i = 0; i < 1024; i++) words[i] = 32'hFFFFFFFF;
    w0 = wen_count;
    pulse_start(11'd1024, 8'h3C);
    send_words(1024, 0);
    wait_done(2100);
    chk("full_sum", msumw, 32'hFFFFFC00);
    chk("full_last_addr", {22'd0, last_waddr}, 32'd1023);
    chk("full_wen_count", wen_count - w0, 32'd1024);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_pcv", {24'd0, PC_Valid}, 32'h3C);

    // Abort after two of four words, with a third transfer offered alongside.
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    w0 = wen_count;
    pulse_start(11'd4, 8'h0F);
    send_words(2, 0);
    bus.in_valid = 1'b1; bus.in_data = words[2]; abort = 1'b1;
    @(negedge clk);
    check_zero("abort");
    #1 abort = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_wen_count", wen_count - w0, 32'd2);

    // Rerun, reset in VERIFY, then a clean load.
    pulse_start(11'd4, 8'h0F);
    send_words(4, 0);
    repeat (3) @(negedge clk);
    chk("verify_addr", {22'd0, bus.Addr_FIO_ICache}, 32'd2);
    #1 rst_n = 1'b0;
    #1 check_zero("reset_mid_verify");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_pcv", {24'd0, PC_Valid}, 32'd0);
    pulse_start(11'd4, 8'h81);
    send_words(4, 0);
    wait_done(40);
    chk("rerun_done", {31'd0, done}, 32'd1);
    chk("rerun_pcv", {24'd0, PC_Valid}, 32'h81);
    check_mem(4);

    // Randomized loads: lengths, gaps, masks, faults, aborts, stray starts.
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 2047);
      else        n = $urandom_range(1, 48);
      for (int i = 0; i < 48; i++) words[i] = $urandom;
      fault_en = ((r == 1) || (r == 2)) && (n >= 1) && (n <= 48);
      fault_addr = (n >= 1 && n <= 48) ? 10'($urandom_range(0, n - 1)) : 10'd0;
      @(negedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = $urandom;
      pulse_start(11'(n), 8'($urandom_range(0, 255)));
      bus.in_valid = 1'b0;
      if (r == 0) begin
        chk("rand_illegal_err_code", {30'd0, err_code}, 32'd1);
      end else if (r == 3) begin
        npart = $urandom_range(0, n - 1);
        send_words(npart, 2);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
      end else begin
        send_words(n, 2);
        wait_done(2 * n + 20);
        if (!fault_en) check_mem(n);
      end
      fault_en = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
